// File: rtl/axi_stream_arbiter_pkg.sv
// Shared types and defaults for the two-source packet arbiter.
// Holds the arbiter FSM encoding and the default widths.
package axi_stream_arbiter_pkg;

    localparam int unsigned N_DEFAULT     = 64;
    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // Lock state that keeps the given source owning the master side.
    function automatic arb_state_e lock_state(input logic src);
        return src ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/axi_stream_out_reg.sv
// Single-stage valid/ready register used as the arbiter's master port.
// Accepts a new beat whenever it is empty or being drained.
module axi_stream_out_reg
    import axi_stream_arbiter_pkg::*;
#(
    parameter int unsigned W = N_DEFAULT + 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Load on accept, otherwise hold the beat stable for downstream.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    // Register state; zeroed on reset so the source tag reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axi_stream_arbiter.sv
// Two-into-one packet arbiter with round-robin tie break.
// A granted source owns the master side until its last beat.
module axi_stream_arbiter
    import axi_stream_arbiter_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     s0_data,
    input  logic             s0_last,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [N-1:0]     s1_data,
    input  logic             s1_last,
    input  logic             s1_valid,
    output logic             s1_ready,
    output logic [N-1:0]     m_data,
    output logic             m_last,
    output logic             m_src,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    localparam int unsigned W = N + 2;

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             last_grant_q;
    logic             last_grant_d;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt0_d;
    logic [CNT_W-1:0] cnt1_q;
    logic [CNT_W-1:0] cnt1_d;

    logic             accept;
    logic             grant_vld;
    logic             grant_src;
    logic             xfer;
    logic             xfer_last;
    logic [N-1:0]     xfer_data;
    logic [W-1:0]     in_bus;
    logic [W-1:0]     out_bus;

    // Pick the owner: locked source, else single requester, else round-robin.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = 1'b0;
        unique case (state_q)
            LOCK0: begin
                grant_vld = 1'b1;
                grant_src = 1'b0;
            end
            LOCK1: begin
                grant_vld = 1'b1;
                grant_src = 1'b1;
            end
            default: begin
                unique case (1'b1)
                    (s0_valid & s1_valid): begin
                        grant_vld = 1'b1;
                        grant_src = ~last_grant_q;
                    end
                    (s0_valid & ~s1_valid): begin
                        grant_vld = 1'b1;
                        grant_src = 1'b0;
                    end
                    (~s0_valid & s1_valid): begin
                        grant_vld = 1'b1;
                        grant_src = 1'b1;
                    end
                    default: begin
                        grant_vld = 1'b0;
                    end
                endcase
            end
        endcase
    end

    assign s0_ready  = ~reset & grant_vld & ~grant_src & accept;
    assign s1_ready  = ~reset & grant_vld & grant_src & accept;

    assign xfer      = grant_src ? (s1_valid & s1_ready)
                                 : (s0_valid & s0_ready);
    assign xfer_last = grant_src ? s1_last : s0_last;
    assign xfer_data = grant_src ? s1_data : s0_data;

    // Advance the lock, round-robin memory and packet counters on transfers.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (xfer) begin
            if (xfer_last) begin
                state_d      = IDLE;
                last_grant_d = grant_src;
                if (grant_src) begin
                    cnt1_d = cnt1_q + CNT_W'(1);
                end else begin
                    cnt0_d = cnt0_q + CNT_W'(1);
                end
            end else begin
                state_d = lock_state(grant_src);
            end
        end
    end

    // Arbiter state; reset favours source 0 on the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign in_bus   = {grant_src, xfer_last, xfer_data};
    assign m_src    = out_bus[W-1];
    assign m_last   = out_bus[W-2];
    assign m_data   = out_bus[N-1:0];
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

    axi_stream_out_reg #(
        .W (W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_bus),
        .in_valid  (xfer),
        .in_ready  (accept),
        .out_data  (out_bus),
        .out_valid (m_valid),
        .out_ready (m_ready)
    );

endmodule

// File: tb/tb_axi_stream_arbiter.sv
// Bench for the two-source packet arbiter: reference model,
// per-source scoreboards, directed scenarios and random traffic.
module tb_axi_stream_arbiter;
    import axi_stream_arbiter_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        int          c;
        logic [15:0] d;
        logic        s;
        logic        l;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s0_data = '0;
    logic        s0_last = 1'b0;
    logic        s0_valid = 1'b0;
    logic        s0_ready;
    logic [15:0] s1_data = '0;
    logic        s1_last = 1'b0;
    logic        s1_valid = 1'b0;
    logic        s1_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_src;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [3:0]  pkt_cnt0;
    logic [3:0]  pkt_cnt1;

    axi_stream_arbiter #(
        .N     (16),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_src    (m_src),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    int t0 = 0;
    int first_s1r = -1;
    bit started = 1'b0;
    bit en0 = 1'b1;
    bit en1 = 1'b1;

    beat_t q0[$];
    beat_t q1[$];
    beat_t sb0[$];
    beat_t sb1[$];
    ent_t  lg[$];

    // Reference model state: owner (-1 none), last winner, output slot, counts.
    int          md_lock = -1;
    bit          md_lg = 1'b1;
    bit          md_ov = 1'b0;
    logic [15:0] md_d = '0;
    bit          md_l = 1'b0;
    bit          md_s = 1'b0;
    logic [3:0]  md_c0 = '0;
    logic [3:0]  md_c1 = '0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc_n);
        end
    endfunction

    function automatic bit mdl_ready(int src);
        int g;
        if (reset) return 1'b0;
        if (md_lock >= 0) g = md_lock;
        else if (s0_valid && s1_valid) g = md_lg ? 0 : 1;
        else if (s0_valid) g = 0;
        else if (s1_valid) g = 1;
        else g = -1;
        return (g == src) && (!md_ov || m_ready);
    endfunction

    // Model advance at each rising edge from the inputs that were presented.
    always @(posedge clk) begin
        int x;
        bit r0;
        bit r1;
        cyc_n++;
        if (reset) begin
            md_lock = -1;
            md_lg   = 1'b1;
            md_ov   = 1'b0;
            md_s    = 1'b0;
            md_c0   = '0;
            md_c1   = '0;
        end else begin
            r0 = mdl_ready(0);
            r1 = mdl_ready(1);
            x  = (s0_valid && r0) ? 0 : ((s1_valid && r1) ? 1 : -1);
            if (!md_ov || m_ready) md_ov = (x >= 0);
            if (x >= 0) begin
                md_d = (x == 1) ? s1_data : s0_data;
                md_l = (x == 1) ? s1_last : s0_last;
                md_s = (x == 1);
                if (x == 1) void'(q1.pop_front());
                else void'(q0.pop_front());
                if (md_l) begin
                    md_lock = -1;
                    md_lg   = (x == 1);
                    if (x == 1) md_c1 = md_c1 + 4'd1;
                    else md_c0 = md_c0 + 4'd1;
                end else begin
                    md_lock = x;
                end
            end
        end
    end

    // Compare DUT against the model mid-cycle; scoreboard output beats.
    always @(negedge clk) begin
        beat_t b;
        ent_t  e;
        if (started) begin
            chk("s0_ready", s0_ready, mdl_ready(0));
            chk("s1_ready", s1_ready, mdl_ready(1));
            chk("m_valid", m_valid, md_ov);
            chk("m_src", m_src, md_s);
            if (md_ov) begin
                chk("m_data", m_data, md_d);
                chk("m_last", m_last, md_l);
            end
            chk("pkt_cnt0", pkt_cnt0, md_c0);
            chk("pkt_cnt1", pkt_cnt1, md_c1);
            if (s1_ready && first_s1r < 0) first_s1r = cyc_n - t0;
            if (m_valid && m_ready) begin
                e.c = cyc_n - t0;
                e.d = m_data;
                e.s = m_src;
                e.l = m_last;
                lg.push_back(e);
                if (m_src) begin
                    chk("sb1_nonempty", sb1.size() > 0, 1);
                    if (sb1.size() > 0) begin
                        b = sb1.pop_front();
                        chk("sb1_beat", {m_data, m_last}, b);
                    end
                end else begin
                    chk("sb0_nonempty", sb0.size() > 0, 1);
                    if (sb0.size() > 0) begin
                        b = sb0.pop_front();
                        chk("sb0_beat", {m_data, m_last}, b);
                    end
                end
            end
        end
    end

    task automatic drive();
        s0_valid = en0 && (q0.size() > 0);
        s0_data  = (q0.size() > 0) ? q0[0].d : 16'h0;
        s0_last  = (q0.size() > 0) ? q0[0].l : 1'b0;
        s1_valid = en1 && (q1.size() > 0);
        s1_data  = (q1.size() > 0) ? q1[0].d : 16'h0;
        s1_last  = (q1.size() > 0) ? q1[0].l : 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic send(int src, int len, logic [15:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = base + 16'(i);
            b.l = (i == len - 1);
            if (src == 1) begin
                q1.push_back(b);
                sb1.push_back(b);
            end else begin
                q0.push_back(b);
                sb0.push_back(b);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        en0 = 1'b1;
        en1 = 1'b1;
        m_ready = 1'b1;
        cyc();
        started = 1'b1;
        cyc();
        q0.delete();
        q1.delete();
        sb0.delete();
        sb1.delete();
        reset = 1'b0;
        drive();
        lg.delete();
        t0 = cyc_n;
        first_s1r = -1;
    endtask

    task automatic wait_drain(int budget, string nm);
        int i = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_valid) && i < budget) begin
            cyc();
            i++;
        end
        chk(nm, i < budget, 1);
    endtask

    logic [15:0] exp_d[5];
    logic        exp_s[5];

    initial begin
        bit found;

        // Tie right after reset: s0 first, then s1, back to back.
        apply_reset();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_src", m_src, 0);
        chk("rst_cnt0", pkt_cnt0, 0);
        chk("rst_cnt1", pkt_cnt1, 0);
        send(0, 3, 16'hA000);
        send(1, 2, 16'hB000);
        drive();
        wait_drain(30, "tie_drain");
        exp_d = '{16'hA000, 16'hA001, 16'hA002, 16'hB000, 16'hB001};
        exp_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        chk("tie_beats", lg.size(), 5);
        for (int i = 0; i < 5 && i < lg.size(); i++) begin
            chk("tie_cycle", lg[i].c, i + 1);
            chk("tie_data", lg[i].d, exp_d[i]);
            chk("tie_src", lg[i].s, exp_s[i]);
        end
        chk("tie_cnt0", pkt_cnt0, 1);
        chk("tie_cnt1", pkt_cnt1, 1);

        // s1 waits out a whole 4-beat s0 packet.
        apply_reset();
        send(0, 4, 16'hC000);
        send(1, 1, 16'hC100);
        drive();
        wait_drain(30, "lock_drain");
        chk("lock_s1_ready_first", first_s1r, 4);
        chk("lock_beats", lg.size(), 5);
        for (int i = 0; i < 5 && i < lg.size(); i++) begin
            chk("lock_src", lg[i].s, (i == 4));
        end

        // Round-robin on continuous single-beat packets.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            send(0, 1, 16'h1000 + 16'(i));
            send(1, 1, 16'h2000 + 16'(i));
        end
        drive();
        wait_drain(40, "rr_drain");
        chk("rr_beats", lg.size(), 8);
        for (int i = 0; i < 8 && i < lg.size(); i++) begin
            chk("rr_src", lg[i].s, i % 2);
        end
        chk("rr_cnt0", pkt_cnt0, 4);
        chk("rr_cnt1", pkt_cnt1, 4);

        // Downstream stall holding 0xDEAD for 5 cycles.
        apply_reset();
        send(0, 6, 16'hDEAB);
        drive();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (m_valid && m_data == 16'hDEAD) found = 1'b1;
        end
        chk("bp_found", found, 1);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold_data", m_data, 16'hDEAD);
            chk("bp_hold_valid", m_valid, 1);
            chk("bp_s0_ready", s0_ready, 0);
            chk("bp_s1_ready", s1_ready, 0);
        end
        m_ready = 1'b1;
        wait_drain(30, "bp_drain");
        chk("bp_beats", lg.size(), 6);
        for (int i = 0; i < 6 && i < lg.size(); i++) begin
            chk("bp_seq", lg[i].d, 16'hDEAB + 16'(i));
        end

        // Counter wrap on a 4-bit counter.
        apply_reset();
        for (int i = 0; i < 17; i++) send(0, 1, 16'h3000 + 16'(i));
        drive();
        wait_drain(60, "wrap_drain");
        chk("wrap_cnt0", pkt_cnt0, 1);
        chk("wrap_cnt1", pkt_cnt1, 0);

        // Reset in the middle of a 4-beat s1 packet.
        apply_reset();
        send(1, 4, 16'hC0C0);
        drive();
        cyc();
        cyc();
        reset = 1'b1;
        drive();
        cyc();
        chk("mid_m_valid", m_valid, 0);
        chk("mid_state", dut.state_q, IDLE);
        chk("mid_cnt0", pkt_cnt0, 0);
        chk("mid_cnt1", pkt_cnt1, 0);
        chk("mid_fwd", lg.size(), 2);
        q1.delete();
        sb1.delete();
        reset = 1'b0;
        drive();
        lg.delete();
        t0 = cyc_n;
        send(0, 2, 16'hD000);
        drive();
        wait_drain(30, "mid_drain");
        chk("mid_new_beats", lg.size(), 2);
        for (int i = 0; i < 2 && i < lg.size(); i++) begin
            chk("mid_new_src", lg[i].s, 0);
            chk("mid_new_data", lg[i].d, 16'hD000 + 16'(i));
        end
        chk("mid_new_cnt0", pkt_cnt0, 1);
        chk("mid_new_cnt1", pkt_cnt1, 0);

        // Random traffic with upstream gaps and downstream stalls.
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            if (q0.size() < 2 && $urandom_range(3, 0) == 0)
                send(0, int'($urandom_range(4, 1)), 16'($urandom));
            if (q1.size() < 2 && $urandom_range(3, 0) == 0)
                send(1, int'($urandom_range(4, 1)), 16'($urandom));
            en0 = ($urandom_range(4, 0) != 0);
            en1 = ($urandom_range(4, 0) != 0);
            m_ready = ($urandom_range(3, 0) != 0);
            drive();
            cyc();
        end
        en0 = 1'b1;
        en1 = 1'b1;
        m_ready = 1'b1;
        drive();
        wait_drain(300, "rand_drain");
        chk("rand_sb0_empty", sb0.size(), 0);
        chk("rand_sb1_empty", sb1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 required");
        $fatal(1);
    end

endmodule

// File: doc/axi_stream_arbiter.md
AXI_STREAM_ARBITER -- requirements
Module: axi_stream_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the payload data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the packet counter width.
REQ-003 Port clk SHALL be an input, 1 bit wide, and be the single clock; all logic is rising-edge.
REQ-004 Port reset SHALL be an input, 1 bit wide, and be a synchronous, active-high reset.
REQ-005 Ports s0_data (in, N), s0_last (in, 1), s0_valid (in, 1) and s0_ready (out, 1) SHALL form slave stream 0.
REQ-006 Ports s1_data (in, N), s1_last (in, 1), s1_valid (in, 1) and s1_ready (out, 1) SHALL form slave stream 1.
REQ-007 Ports m_data (out, N), m_last (out, 1), m_src (out, 1) and m_valid (out, 1) SHALL form the master stream; m_src is the source index of the current beat.
REQ-008 Port m_ready SHALL be an input, 1 bit wide, and be the downstream acceptance (typically the register slice's s_ready).
REQ-009 Ports pkt_cnt0 and pkt_cnt1 SHALL be outputs, CNT_W bits wide, counting completed packets forwarded from each source.

Function
REQ-010 The block SHALL merge two packetised streams into one, and SHALL never interleave beats of different packets on the master side.
REQ-011 A beat SHALL transfer on any stream when valid and ready are both high on a rising edge.
REQ-012 The master output SHALL be a single register stage: the accepted beat appears on m_* on the following cycle, giving a latency of 1.
REQ-013 The output register SHALL accept a new beat when (~m_valid | m_ready), which gives full throughput with no bubbles.
REQ-014 The arbiter SHALL be an FSM with states IDLE, LOCK0 and LOCK1.
REQ-015 In IDLE, with exactly one sX_valid high, the block SHALL grant source X.
REQ-016 In IDLE, with both valid, the block SHALL grant the source not recorded in last_grant (round-robin).
REQ-017 In IDLE, with no valid, the block SHALL grant nothing.
REQ-018 In IDLE, the granted source's ready SHALL equal the output-accept condition and the other source's ready SHALL be 0; arbitration and first-beat transfer occur in the same cycle.
REQ-019 In IDLE, a granted beat with last=0 SHALL move the FSM to LOCKX.
REQ-020 In IDLE, a granted beat with last=1 (single-beat packet) SHALL keep the FSM in IDLE.
REQ-021 In LOCKX, only sX_ready SHALL be allowed high, equal to the output-accept condition; the other source's ready SHALL be held 0 regardless of its valid.
REQ-022 In LOCKX, a transfer with last=1 SHALL return the FSM to IDLE; IDLE re-arbitrates on the next cycle.
REQ-023 last_grant SHALL update to X on every packet-ending transfer (last=1) from source X.
REQ-024 pkt_cntX SHALL increment by 1 on each last=1 transfer from source X into the output register, and SHALL wrap modulo 2^CNT_W.
REQ-025 A packet-ending transfer and a new-packet grant SHALL NOT coincide for different sources in the same cycle; back-to-back packets from the same source in IDLE are permitted.
REQ-026 Upstream stall SHALL be handled: in LOCKX with sX_valid=0, the FSM SHALL hold LOCKX and m_valid SHALL drop after the output register drains.
REQ-027 Downstream stall SHALL be handled: with m_valid=1 and m_ready=0, m_data, m_last and m_src SHALL hold stable and all sX_ready SHALL be 0.
REQ-028 The block SHALL never drop or duplicate a beat.

Reset
REQ-029 While reset is high at a clock edge, the next state SHALL be: FSM=IDLE, m_valid=0, last_grant=1 (so source 0 wins the first tie), pkt_cnt0=0, pkt_cnt1=0.
REQ-030 During and after reset, s0_ready and s1_ready SHALL be 0 while reset is asserted.
REQ-031 m_data and m_last SHALL have don't-care reset values; m_src SHALL reset to 0.
REQ-032 A reset asserted mid-packet SHALL abandon the packet: no further beats of it are forwarded, and the partial packet is not counted.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE, LOCK0, LOCK1) and the default N/CNT_W constants.
REQ-034 One sub-module, axi_stream_out_reg (the N+2-bit output register with valid/ready), SHALL be used; the arbiter FSM and counters stay in the top module.

Verification
REQ-035 The bench SHALL cover a tie after reset: s0 sends a 3-beat packet (A0..A2) and s1 a 2-beat packet (B0,B1), both valid at cycle 0 with m_ready=1 -> master emits A0,A1,A2,B0,B1 on consecutive cycles starting at cycle 1, m_src=0,0,0,1,1, pkt_cnt0=1, pkt_cnt1=1.
REQ-036 The bench SHALL cover interleave protection: s1 is valid throughout s0's 4-beat packet -> s1_ready stays 0 until s0's last beat transfers, and no s1 beat appears between s0 beats.
REQ-037 The bench SHALL cover round-robin: both sources continuously offer 1-beat packets -> m_src alternates 0,1,0,1 and each counter equals 4 after 8 output beats.
REQ-038 The bench SHALL cover backpressure: m_ready=0 for 5 cycles mid-packet with data 0xDEAD held -> m_data stays 0xDEAD, both readies are 0, and after release the sequence resumes with no loss or duplication.
REQ-039 The bench SHALL cover counter wrap: with CNT_W=4 and 17 single-beat packets on s0 -> pkt_cnt0=1.
REQ-040 The bench SHALL cover reset mid-packet: reset is asserted after beat 2 of a 4-beat s1 packet -> the next cycle shows m_valid=0, FSM in IDLE, both counters 0, and a following s0 packet is granted normally.
